// File: rtl/if_fetch_buffer.sv
// Instruction fetch front-end: issues sequential word requests, buffers in-order responses
// with their PCs, and hands them to decode; EX redirects flush and drop wrong-path data.
module if_fetch_buffer #(
    parameter logic [31:0] CPU_RESET_VECTOR = 32'h0,
    parameter int unsigned DEPTH            = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc_p4,
    output logic [31:0] o_if_instr,
    input  logic        i_id_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [CW:0]   in_use;
    logic [31:0]   redirect_pc;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    assign redirect_pc    = {i_redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^i_redirect_pc[1:0];

    // Credit counts only registered state, so a pop this cycle frees nothing until next cycle.
    assign in_use           = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign o_imem_req_valid = !rst && !i_redirect && (in_use < DepthC);
    assign o_imem_req_addr  = fetch_pc_q;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign o_if_valid = (fifo_cnt_q != '0) && !i_redirect;
    assign o_if_pc    = pc_mem_q[rd_ptr_q];
    assign o_if_instr = instr_mem_q[rd_ptr_q];
    assign o_if_pc_p4 = o_if_pc + 32'd4;

    assign pop  = o_if_valid && i_id_ready;
    assign push = i_imem_rsp_valid && !i_redirect && (drop_cnt_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Everything still in flight after this cycle's response belongs to the old path.
            outst_d    = outst_q - CW'(i_imem_rsp_valid);
            drop_cnt_d = outst_d;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
            if (i_imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= CPU_RESET_VECTOR;
            rsp_pc_q   <= CPU_RESET_VECTOR;
            outst_q    <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so the presented PC/instruction read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
            instr_mem_q[wr_ptr_q] <= i_imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: a default-vector instance with a latency-programmable
// memory model, and a second instance with a near-wrap reset vector.
module tb_if_fetch_buffer;

    localparam logic [31:0] Key = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc, if_pc_p4, if_instr;
    logic        id_ready = 1'b1;

    logic        h_redirect = 1'b0;
    logic [31:0] h_redirect_pc = 32'h0;
    logic        h_req_valid;
    logic [31:0] h_req_addr;
    logic        h_req_ready = 1'b1;
    logic        h_rsp_valid = 1'b0;
    logic [31:0] h_rsp_data = 32'h0;
    logic        h_if_valid;
    logic [31:0] h_if_pc, h_if_pc_p4, h_if_instr;
    logic        h_id_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 1;

    logic [31:0] mq[$];
    int          mdue[$];
    logic [31:0] req_log[$], pop_pc[$], pop_instr[$], pop_p4[$];
    logic [31:0] h_req_log[$], h_pop_pc[$], h_pop_instr[$], h_pop_p4[$];

    always #5 clk = ~clk;

    if_fetch_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req_valid (req_valid),
        .o_imem_req_addr  (req_addr),
        .i_imem_req_ready (req_ready),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .o_if_valid       (if_valid),
        .o_if_pc          (if_pc),
        .o_if_pc_p4       (if_pc_p4),
        .o_if_instr       (if_instr),
        .i_id_ready       (id_ready)
    );

    if_fetch_buffer #(.CPU_RESET_VECTOR(32'hFFFFFFF8), .DEPTH(4)) dut_hi (
        .clk              (clk),
        .rst              (rst),
        .i_redirect       (h_redirect),
        .i_redirect_pc    (h_redirect_pc),
        .o_imem_req_valid (h_req_valid),
        .o_imem_req_addr  (h_req_addr),
        .i_imem_req_ready (h_req_ready),
        .i_imem_rsp_valid (h_rsp_valid),
        .i_imem_rsp_data  (h_rsp_data),
        .o_if_valid       (h_if_valid),
        .o_if_pc          (h_if_pc),
        .o_if_pc_p4       (h_if_pc_p4),
        .o_if_instr       (h_if_instr),
        .i_id_ready       (h_id_ready)
    );

    // Memory for the main instance: in-order, answers mem_lat cycles after the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                mdue.delete();
            end else begin
                if (req_valid && req_ready) begin
                    mq.push_back(req_addr);
                    mdue.push_back(cyc + mem_lat);
                    req_log.push_back(req_addr);
                end
                if (if_valid && id_ready) begin
                    pop_pc.push_back(if_pc);
                    pop_instr.push_back(if_instr);
                    pop_p4.push_back(if_pc_p4);
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst && mq.size() > 0 && mdue[0] <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = mq[0] ^ Key;
                void'(mq.pop_front());
                void'(mdue.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = 32'h0;
            end
        end
    end

    // Memory for the wrap instance: always ready, fixed 1-cycle latency.
    initial begin
        logic        hf;
        logic [31:0] ha;
        forever begin
            @(negedge clk);
            hf = !rst && h_req_valid && h_req_ready;
            ha = h_req_addr;
            if (!rst) begin
                if (hf) h_req_log.push_back(ha);
                if (h_if_valid && h_id_ready) begin
                    h_pop_pc.push_back(h_if_pc);
                    h_pop_instr.push_back(h_if_instr);
                    h_pop_p4.push_back(h_if_pc_p4);
                end
            end
            @(posedge clk);
            #1;
            h_rsp_valid = hf && !rst;
            h_rsp_data  = hf ? (ha ^ Key) : 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete(); pop_pc.delete(); pop_instr.delete(); pop_p4.delete();
        h_req_log.delete(); h_pop_pc.delete(); h_pop_instr.delete(); h_pop_p4.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 00000000", req_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 00000000", if_instr); end
        checks++; if (h_req_addr !== 32'hFFFFFFF8) begin errors++; $display("FAIL reset_hi_addr: got %h want fffffff8", h_req_addr); end
    endtask

    task automatic test_stream();
        mem_lat = 1; req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got v=%b a=%h want v=1 a=00000000", req_valid, req_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c0: got %b want 0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c1: got %b want 0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== Key || if_pc_p4 !== 32'h4) begin
            errors++; $display("FAIL stream_first_out: got v=%b pc=%h i=%h p4=%h want v=1 pc=0 i=%h p4=4", if_valid, if_pc, if_instr, if_pc_p4, Key);
        end
        repeat (10) step();
        checks++; if (pop_pc.size() < 8) begin errors++; $display("FAIL stream_pop_count: got %0d want >=8", pop_pc.size()); end
        for (int i = 0; i < 8 && i < pop_pc.size() && i < req_log.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== (32'(4 * i) ^ Key) ||
                pop_p4[i] !== 32'(4 * i + 4) || req_log[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL stream_entry_%0d: got pc=%h i=%h p4=%h req=%h want pc=%h", i, pop_pc[i], pop_instr[i], pop_p4[i], req_log[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1; req_ready = 1'b1; id_ready = 1'b0;
        do_reset();
        repeat (12) step();
        @(negedge clk);
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
        step();
        id_ready = 1'b1;
        repeat (12) step();
        checks++; if (pop_pc.size() < 4) begin errors++; $display("FAIL bp_pop_count: got %0d want >=4", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== (32'(4 * i) ^ Key)) begin
                errors++; $display("FAIL bp_order_%0d: got pc=%h i=%h want pc=%h", i, pop_pc[i], pop_instr[i], 32'(4 * i));
            end
        end
        checks++; if (req_log.size() < 5 || req_log[4] !== 32'h10) begin errors++; $display("FAIL bp_resume: got n=%0d want 5th req 00000010", req_log.size()); end
    endtask

    task automatic test_req_stall();
        mem_lat = 1; req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        repeat (3) step();
        req_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'hC) begin errors++; $display("FAIL stall_addr: got v=%b a=%h want v=1 a=0000000c", req_valid, req_addr); end
        end
        #1;
        checks++; if (req_log.size() != 3) begin errors++; $display("FAIL stall_req_count: got %0d want 3", req_log.size()); end
        step();
        req_ready = 1'b1;
        repeat (10) step();
        checks++; if (pop_pc.size() < 8) begin errors++; $display("FAIL stall_pop_count: got %0d want >=8", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++;
            if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== (32'(4 * i) ^ Key)) begin
                errors++; $display("FAIL stall_order_%0d: got pc=%h want %h", i, pop_pc[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        mem_lat = 3; req_ready = 1'b1; id_ready = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir0_req_valid: got %b want 0", req_valid); end
        step();
        redirect = 1'b0;
        repeat (3) step();
        // 0x20 response is on the bus now, with 0x24/0x28 still in flight.
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        checks++; if (req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle: got rv=%b iv=%b want 0 0", req_valid, if_valid); end
        checks++; if (req_log.size() != 3 || req_log[0] !== 32'h20 || req_log[2] !== 32'h28) begin
            errors++; $display("FAIL redir_outstanding: got n=%0d want 3 reqs 20..28", req_log.size());
        end
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin errors++; $display("FAIL redir_new_req: got v=%b a=%h want v=1 a=00000100", req_valid, req_addr); end
        repeat (10) step();
        checks++; if (pop_pc.size() < 2) begin errors++; $display("FAIL redir_pop_count: got %0d want >=2", pop_pc.size()); end
        else begin
            checks++; if (pop_pc[0] !== 32'h100 || pop_instr[0] !== (32'h100 ^ Key)) begin errors++; $display("FAIL redir_first_out: got pc=%h i=%h want 00000100", pop_pc[0], pop_instr[0]); end
            checks++; if (pop_pc[1] !== 32'h104) begin errors++; $display("FAIL redir_second_out: got %h want 00000104", pop_pc[1]); end
        end
        mem_lat = 1;
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (8) step();
        checks++; if (h_pop_pc.size() < 3) begin errors++; $display("FAIL wrap_pop_count: got %0d want >=3", h_pop_pc.size()); end
        else begin
            checks++; if (h_pop_pc[0] !== 32'hFFFFFFF8 || h_pop_p4[0] !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc0: got %h/%h want fffffff8/fffffffc", h_pop_pc[0], h_pop_p4[0]); end
            checks++; if (h_pop_pc[1] !== 32'hFFFFFFFC || h_pop_p4[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h/%h want fffffffc/00000000", h_pop_pc[1], h_pop_p4[1]); end
            checks++; if (h_pop_pc[2] !== 32'h0 || h_pop_instr[2] !== Key) begin errors++; $display("FAIL wrap_pc2: got %h/%h want 00000000/%h", h_pop_pc[2], h_pop_instr[2], Key); end
        end
        checks++; if (h_req_log.size() < 3 || h_req_log[2] !== 32'h0) begin errors++; $display("FAIL wrap_req: got n=%0d want 3rd req 00000000", h_req_log.size()); end
    endtask

    task automatic test_async_reset();
        mem_lat = 1; req_ready = 1'b1; id_ready = 1'b0;
        do_reset();
        repeat (4) step();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", if_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL arst_valids: got rv=%b iv=%b want 0 0", req_valid, if_valid); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0 || req_addr !== 32'h0) begin
            errors++; $display("FAIL arst_data: got pc=%h i=%h a=%h want all 0", if_pc, if_instr, req_addr);
        end
        checks++; if (h_req_addr !== 32'hFFFFFFF8 || h_if_valid !== 1'b0) begin errors++; $display("FAIL arst_hi: got a=%h v=%b want fffffff8 0", h_req_addr, h_if_valid); end
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        id_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin errors++; $display("FAIL arst_restart: got v=%b a=%h want v=1 a=00000000", req_valid, req_addr); end
        repeat (6) step();
        checks++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4) begin
            errors++; $display("FAIL arst_after: got n=%0d want pcs 0,4", pop_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
